// File: rtl/piso_tx.sv
// Parallel-in, serial-out transmitter: one start bit (0), WIDTH data bits LSB first,
// one stop bit (1), each bit held CLKS_PER_BIT cycles; done pulses once per frame.
module piso_tx #(
   parameter int WIDTH        = 8,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] D,
   input  logic             E,
   output logic             ready,
   output logic             busy,
   output logic             Q,
   output logic             done
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] IDX_MAX = IW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t           state, state_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic [IW-1:0]    idx, idx_n;
   logic [WIDTH-1:0] sh, sh_n;
   logic             q_n, done_n;

   logic bit_end;
   assign bit_end = (cnt == CNT_MAX);

   // NOTE: every signal gets its default before the case so no path leaves one unassigned (no latches).
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      idx_n   = idx;
      sh_n    = sh;
      done_n  = 1'b0;
      unique case (state)
         IDLE: begin
            if (E) begin
               sh_n    = D;
               cnt_n   = '0;
               idx_n   = '0;
               state_n = START;
            end
         end
         START: begin
            if (bit_end) begin
               cnt_n   = '0;
               idx_n   = '0;
               state_n = DATA;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         DATA: begin
            if (bit_end) begin
               cnt_n = '0;
               sh_n  = sh >> 1;
               if (idx == IDX_MAX) begin
                  state_n = STOP;
               end else begin
                  idx_n = idx + 1'b1;
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         STOP: begin
            if (bit_end) begin
               cnt_n   = '0;
               state_n = IDLE;
               done_n  = 1'b1;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Line level is derived from the state being entered so Q can be a plain flop.
   always_comb begin
      q_n = 1'b1;
      unique case (state_n)
         IDLE:    q_n = 1'b1;
         START:   q_n = 1'b0;
         DATA:    q_n = sh_n[0];
         STOP:    q_n = 1'b1;
         default: q_n = 1'b1;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= '0;
         idx   <= '0;
         sh    <= '0;
         Q     <= 1'b1;
         done  <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         idx   <= idx_n;
         sh    <= sh_n;
         Q     <= q_n;
         done  <= done_n;
      end
   end

   assign ready = (state == IDLE);
   assign busy  = ~ready;

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: stimulus pushes accepted words into a queue; a line monitor
// decodes each serial frame from Q alone and compares it against the queue.
module tb_piso_tx;

   localparam int W  = 8;
   localparam int C  = 4;
   localparam int WS = 4;
   localparam int CS = 1;

   logic         clk   = 1'b0;
   logic         reset = 1'b0;
   logic [W-1:0] d     = '0;
   logic         e     = 1'b0;
   logic         ready, busy, q, done;

   logic [WS-1:0] d_s = '0;
   logic          e_s = 1'b0;
   logic          ready_s, busy_s, q_s, done_s;

   piso_tx #(.WIDTH(W), .CLKS_PER_BIT(C)) dut (
      .clk(clk), .reset(reset), .D(d), .E(e),
      .ready(ready), .busy(busy), .Q(q), .done(done)
   );

   piso_tx #(.WIDTH(WS), .CLKS_PER_BIT(CS)) dut_small (
      .clk(clk), .reset(reset), .D(d_s), .E(e_s),
      .ready(ready_s), .busy(busy_s), .Q(q_s), .done(done_s)
   );

   always #5 clk = ~clk;

   int           n_checks = 0;
   int           n_errors = 0;
   logic [W-1:0] exp_q[$];
   int           cyc = 0;

   bit           mon_active   = 1'b0;
   bit           done_due     = 1'b0;
   bit           b2b_pending  = 1'b0;
   int           mon_n        = 0;
   int           last_done_cyc = 0;
   logic [W-1:0] mon_word     = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Line monitor: a frame is 0 for C cycles, W data bits of C cycles each, 1 for C cycles,
   // followed by a single done cycle with Q=1 and ready=1.
   always @(negedge clk) begin
      if (!reset) begin
         check("rst_q", q, 1);
         check("rst_ready", ready, 1);
         check("rst_busy", busy, 0);
         check("rst_done", done, 0);
         if (mon_active && exp_q.size() > 0) void'(exp_q.pop_front());
         mon_active = 1'b0;
         done_due   = 1'b0;
      end else begin
         check("busy_xor_ready", 32'(busy ^ ready), 1);
         if (done_due) begin
            check("done_pulse", done, 1);
            check("done_ready", ready, 1);
            check("gap_q", q, 1);
            if (exp_q.size() == 0) check("frame_unexpected", 1, 0);
            else check("frame_word", mon_word, exp_q.pop_front());
            done_due      = 1'b0;
            last_done_cyc = cyc;
         end else begin
            if (!mon_active && q == 1'b0) begin
               mon_active = 1'b1;
               mon_n      = 0;
               mon_word   = '0;
               if (b2b_pending) check("b2b_gap", cyc, last_done_cyc + 1);
               b2b_pending = 1'b0;
            end
            if (mon_active) begin
               int seg, off;
               seg = mon_n / C;
               off = mon_n % C;
               check("frame_done_low", done, 0);
               check("frame_ready_low", ready, 0);
               if (seg == 0) check("start_bit", q, 0);
               else if (seg <= W) begin
                  if (off == 0) mon_word[seg-1] = q;
                  else check("data_hold", q, mon_word[seg-1]);
               end else check("stop_bit", q, 1);
               mon_n++;
               if (mon_n == (W + 2) * C) begin
                  mon_active = 1'b0;
                  done_due   = 1'b1;
               end
            end else begin
               check("idle_ready", ready, 1);
               check("idle_done", done, 0);
            end
         end
      end
   end

   task automatic wait_ready(output bit ok);
      int k = 0;
      @(negedge clk);
      while (!ready && k < 400) begin
         @(negedge clk);
         k++;
      end
      ok = ready;
      if (!ok) check("ready_timeout", 0, 1);
   endtask

   task automatic send(input logic [W-1:0] w);
      bit ok;
      wait_ready(ok);
      if (!ok) return;
      if (done) b2b_pending = 1'b1;
      d = w;
      e = 1'b1;
      @(posedge clk);
      exp_q.push_back(w);
      #1;
      check("accept_busy", busy, 1);
      check("accept_q", q, 0);
      e = 1'b0;
      d = W'($urandom);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      int sq[WS+2];
      logic [WS-1:0] pat;

      repeat (3) @(negedge clk);
      #2 reset = 1'b1;
      repeat (20) @(negedge clk);

      send(8'hA5);

      // Load 3C, keep E high and move D to FF mid-frame; FF must follow on the done cycle.
      wait_ready(ok);
      d = 8'h3C;
      e = 1'b1;
      @(posedge clk);
      exp_q.push_back(8'h3C);
      #1 check("hold_accept_busy", busy, 1);
      repeat (10) @(posedge clk);
      d = 8'hFF;
      wait_ready(ok);
      check("hold_done_cycle", done, 1);
      b2b_pending = 1'b1;
      @(posedge clk);
      exp_q.push_back(8'hFF);
      #1 check("hold_second_busy", busy, 1);
      e = 1'b0;

      // Abort in DATA bit 3 (frame cycles 17..20 after the accept edge).
      send(8'h00);
      repeat (17) @(posedge clk);
      #2 reset = 1'b0;
      #1;
      check("abort_q", q, 1);
      check("abort_ready", ready, 1);
      check("abort_busy", busy, 0);
      repeat (2) @(negedge clk);
      #2 reset = 1'b1;
      send(8'h81);

      for (int i = 0; i < 100; i++) send(W'($urandom));

      for (int k = 0; k < 200 && (exp_q.size() != 0 || mon_active || done_due); k++)
         @(negedge clk);
      check("queue_drained", exp_q.size(), 0);

      // One-cycle bits on the narrow instance.
      pat   = 4'b1001;
      sq[0] = 0;
      for (int i = 0; i < WS; i++) sq[i+1] = int'(pat[i]);
      sq[WS+1] = 1;
      @(negedge clk);
      d_s = pat;
      e_s = 1'b1;
      @(posedge clk);
      #1 e_s = 1'b0;
      d_s = 4'b0110;
      for (int i = 0; i < WS + 2; i++) begin
         @(negedge clk);
         check("small_q", q_s, sq[i]);
         check("small_done_low", done_s, 0);
      end
      @(negedge clk);
      check("small_done", done_s, 1);
      check("small_ready", ready_s, 1);
      check("small_gap_q", q_s, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 Parameter WIDTH, default 8: number of data bits per frame; legal range 1..32.
REQ-002 Parameter CLKS_PER_BIT, default 4: clock cycles each serial bit is held; legal range 1..65535.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; low forces the reset state immediately, independent of clk.
REQ-005 D  input  WIDTH  parallel data word, sampled only on an accepted load.
REQ-006 E  input  1  load enable; a load is accepted on a rising edge where E=1 and ready=1.
REQ-007 ready  output  1  high only in IDLE; block can accept a load.
REQ-008 busy  output  1  high in START, DATA and STOP; equals ~ready.
REQ-009 Q  output  1  serial line; idle level 1.
REQ-010 done  output  1  one-cycle pulse marking frame completion.

Function
REQ-011 The block SHALL implement states IDLE, START, DATA and STOP, plus a bit-time counter of ceil(log2(CLKS_PER_BIT)) bits (minimum 1) and a bit index of ceil(log2(WIDTH)) bits (minimum 1).
REQ-012 In IDLE, an accepted load SHALL capture D into a WIDTH-bit shift register, clear the bit-time counter and enter START on the same edge.
REQ-013 In IDLE with E=0, state, shift register and Q SHALL be unchanged.
REQ-014 While busy=1, E and D SHALL be ignored; a load is never queued.
REQ-015 Q SHALL be registered: 1 in IDLE, 0 in START, the current shift-register bit 0 in DATA, and 1 in STOP.
REQ-016 Each of START, each DATA bit and STOP SHALL last exactly CLKS_PER_BIT cycles, timed by the bit-time counter counting 0..CLKS_PER_BIT-1 and then wrapping to 0.
REQ-017 Data SHALL be sent LSB first; at each DATA bit boundary the shift register SHALL shift right by one and the bit index SHALL increment.
REQ-018 START->DATA at the end of the start bit-time; DATA->STOP at the end of bit index WIDTH-1; STOP->IDLE at the end of the stop bit-time.
REQ-019 Frame length SHALL be (WIDTH+2)*CLKS_PER_BIT cycles, from the first cycle with Q=0 through the last cycle of STOP.
REQ-020 done SHALL be 1 for exactly the first cycle after STOP->IDLE; ready=1 in that same cycle.
REQ-021 A load accepted in the done cycle SHALL start the next frame; the inter-frame gap is exactly 1 cycle with Q=1.
REQ-022 With CLKS_PER_BIT=1, every bit SHALL last one cycle and the counter SHALL remain 0.
REQ-023 Changes to D after acceptance SHALL NOT affect the frame in flight.

Reset
REQ-024 While reset=0, the block SHALL hold: state=IDLE, Q=1, ready=1, busy=0, done=0, counters=0, shift register=0.
REQ-025 reset asserted mid-frame SHALL abort the frame immediately; no done pulse is generated and the captured data is discarded.
REQ-026 After reset deasserts, the first load SHALL be accepted on the first rising edge with E=1.

Verification (WIDTH=8, CLKS_PER_BIT=4 unless stated)
REQ-027 Release reset, hold E=0 for 20 cycles -> Q=1, ready=1, done=0 throughout.
REQ-028 Load D=8'hA5 (E=1 for 1 cycle) -> Q=0 for 4 cycles; then bits 1,0,1,0,0,1,0,1 for 4 cycles each; then Q=1 for 4 cycles; done=1 for 1 cycle, 41 cycles after the accept edge.
REQ-029 Load 8'h3C, hold E=1 and change D to 8'hFF during the frame -> transmitted bits match 8'h3C; a second frame of 8'hFF starts on the done cycle with a 1-cycle Q=1 gap.
REQ-030 Load 8'h00, assert reset=0 asynchronously in DATA bit 3 -> Q=1, ready=1 before the next edge; no done pulse; after release, 8'h81 transmits correctly.
REQ-031 CLKS_PER_BIT=1, WIDTH=4, load 4'b1001 -> Q sequence 0,1,0,0,1,1 on consecutive cycles; done on the cycle after.
REQ-032 Randomized D with back-to-back loads on done (100 frames) -> decoded words match the accepted words in order; busy equals ~ready in every cycle.
